// File: rtl/ysyx_22050133_ifu_axi_pkg.sv
// ysyx_22050133_ifu_axi_pkg
//   Shared definitions for the AXI instruction-fetch unit: FSM state
//   encoding, AXI transfer-size codes, the NOP instruction encoding and
//   the default reset PC.
package ysyx_22050133_ifu_axi_pkg;

  // Fetch FSM states
  typedef enum logic [1:0] {
    IFU_IDLE  = 2'd0,
    IFU_ADDR  = 2'd1,
    IFU_DATA  = 2'd2,
    IFU_VALID = 2'd3
  } ifu_state_e;

  // AXI ARSIZE encodings (bytes per beat)
  localparam logic [2:0] AXI_SIZE_BYTES_1 = 3'b000;
  localparam logic [2:0] AXI_SIZE_BYTES_2 = 3'b001;
  localparam logic [2:0] AXI_SIZE_BYTES_4 = 3'b010;
  localparam logic [2:0] AXI_SIZE_BYTES_8 = 3'b011;

  // addi x0, x0, 0
  localparam logic [31:0] INST_NOP = 32'h0000_0013;

  localparam logic [63:0] RESET_PC_DEFAULT = 64'h0000_0000_8000_0000;

endpackage

// File: rtl/ysyx_22050133_ifu_axi.sv
// ysyx_22050133_ifu_axi
//   Instruction fetch unit with a single-beat AXI read master. Issues one
//   4-byte fetch at a time, hands the instruction to decode through a
//   valid/ready handshake, and handles control-flow redirects from execute,
//   discarding at most one in-flight beat that belongs to the old path.
//
// Ports
//   clk, rst                 clock, asynchronous active-low reset
//   arvalid/arready, araddr  AXI read-address channel (arsize/arlen constant)
//   rvalid/rready, rdata,    AXI read-data channel
//   rresp
//   inst_valid/inst_ready    handshake toward decode
//   inst, pc, inst_fault     delivered instruction, its address, bus error
//   redirect_valid/_pc       control-flow redirect from execute
module ysyx_22050133_ifu_axi
  import ysyx_22050133_ifu_axi_pkg::*;
#(
  parameter logic [63:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic        arvalid,
  input  logic        arready,
  output logic [63:0] araddr,
  output logic [2:0]  arsize,
  output logic [7:0]  arlen,
  input  logic        rvalid,
  output logic        rready,
  input  logic [63:0] rdata,
  input  logic [1:0]  rresp,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [63:0] pc,
  output logic        inst_fault,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc
);

  ifu_state_e  state, state_next;
  logic [63:0] pc_next, araddr_next;
  logic [31:0] inst_next;
  logic        fault_next;
  // Set when the beat currently in flight belongs to a redirected-away path
  logic        drop, drop_next;
  logic [63:0] redir_pc;
  logic [63:0] pc_inc;

  assign redir_pc = redirect_pc & ~64'h3;
  assign pc_inc   = pc + 64'd4;

  assign arvalid    = (state == IFU_ADDR);
  assign rready     = (state == IFU_DATA);
  assign inst_valid = (state == IFU_VALID);
  assign arsize     = AXI_SIZE_BYTES_4;
  assign arlen      = 8'd0;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IFU_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc         <= RESET_PC;
      araddr     <= RESET_PC;
      inst       <= INST_NOP;
      inst_fault <= 1'b0;
      drop       <= 1'b0;
    end else begin
      pc         <= pc_next;
      araddr     <= araddr_next;
      inst       <= inst_next;
      inst_fault <= fault_next;
      drop       <= drop_next;
    end
  end

  // Next-state and datapath updates. araddr is only loaded on the way into
  // ADDR so it stays stable for the whole address phase; a redirect is
  // always taken in preference to a decode handshake.
  always_comb begin
    state_next  = state;
    pc_next     = pc;
    araddr_next = araddr;
    inst_next   = inst;
    fault_next  = inst_fault;
    drop_next   = drop;

    case (state)
      IFU_IDLE: begin
        state_next = IFU_ADDR;
        if (redirect_valid) begin
          pc_next     = redir_pc;
          araddr_next = redir_pc;
        end
      end

      IFU_ADDR: begin
        // The address already on the bus cannot change; remember to
        // throw away whatever comes back for it.
        if (redirect_valid) begin
          pc_next   = redir_pc;
          drop_next = 1'b1;
        end
        if (arready) begin
          state_next = IFU_DATA;
        end
      end

      IFU_DATA: begin
        if (rvalid) begin
          if (drop || redirect_valid) begin
            state_next  = IFU_ADDR;
            drop_next   = 1'b0;
            pc_next     = redirect_valid ? redir_pc : pc;
            araddr_next = redirect_valid ? redir_pc : pc;
          end else begin
            inst_next  = pc[2] ? rdata[63:32] : rdata[31:0];
            fault_next = (rresp != 2'b00);
            state_next = IFU_VALID;
          end
        end else if (redirect_valid) begin
          pc_next   = redir_pc;
          drop_next = 1'b1;
        end
      end

      IFU_VALID: begin
        if (redirect_valid) begin
          pc_next     = redir_pc;
          araddr_next = redir_pc;
          state_next  = IFU_ADDR;
        end else if (inst_ready) begin
          pc_next     = pc_inc;
          araddr_next = pc_inc;
          state_next  = IFU_ADDR;
        end
      end

      default: begin
        state_next = IFU_IDLE;
      end
    endcase
  end

endmodule
